spi_slave_core: RTL
===================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter WORD_W, default 16, SPI word length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for SCK, SPISIMO and SPISTE.
REQ-003 clk_100  input  1  system clock, 100 MHz; all logic SHALL run on its rising edge.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 SCK  input  1  SPI clock from the external master, asynchronous to clk_100, idle low.
REQ-006 SPISIMO  input  1  master-out slave-in serial data, MSB first.
REQ-007 SPISOMI  output  1  slave-out master-in serial data, MSB first, registered.
REQ-008 SPISTE  input  1  slave select, active low, asynchronous.
REQ-009 txd_data  input  WORD_W  word to transmit; sampled at each word load point.
REQ-010 rxd_data  output  WORD_W  last complete received word, held until the next complete word.
REQ-011 rxd_flag  output  1  one-clk_100 pulse marking a new value on rxd_data.
REQ-012 frame_err  output  1  one-clk_100 pulse: SPISTE deasserted with a partial word.

Function
REQ-013 SPI mode SHALL be CPOL=0, CPHA=0: sample SPISIMO on SCK rise, update SPISOMI on SCK fall.
REQ-014 SCK, SPISIMO and SPISTE SHALL pass through SYNC_STAGES flops; edges SHALL be detected from the synchronized values plus one history flop.
REQ-015 Supported SCK frequency SHALL be <= clk_100/8 (12.5 MHz), each SCK phase >= 4 clk_100 cycles.
REQ-016 States: IDLE (SPISTE high) and ACTIVE (SPISTE low); a 5-bit bit counter runs 0..WORD_W.
REQ-017 IDLE->ACTIVE on synchronized SPISTE fall: load tx shift register from txd_data, counter=0, SPISOMI=txd_data[MSB] on the next cycle.
REQ-018 ACTIVE, SCK rise: shift SPISIMO into rx shift register LSB, counter+1.
REQ-019 Counter reaching WORD_W on a rise: rxd_data <= assembled word and rxd_flag=1 on the following cycle (latency 1 clk_100 from detected edge).
REQ-020 ACTIVE, SCK fall with counter in 1..WORD_W-1: shift tx register left, SPISOMI=new MSB.
REQ-021 ACTIVE, SCK fall with counter==WORD_W: reload tx register from txd_data, counter=0; back-to-back words in one SPISTE frame SHALL be supported.
REQ-022 txd_data updated within 3 clk_100 cycles after rxd_flag SHALL be transmitted in the next word.
REQ-023 ACTIVE->IDLE on synchronized SPISTE rise: counter=0, partial rx bits discarded, rxd_data unchanged, SPISOMI=0; frame_err pulses if counter was 1..WORD_W-1.
REQ-024 SPISTE rise detected in the same cycle as an SCK edge: SPISTE SHALL win and the SCK edge SHALL be ignored.
REQ-025 SCK edges while IDLE SHALL be ignored; SPISOMI SHALL be driven 0 in IDLE (no tristate).
REQ-026 rxd_flag and frame_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 While RSTn low: rxd_data=0, rxd_flag=0, frame_err=0, SPISOMI=0, shift registers=0, counter=0, synchronizers=idle values (SCK 0, SPISTE 1), state IDLE.
REQ-028 RSTn asserted mid-word SHALL abort the word with no rxd_flag or frame_err pulse; after release the block SHALL wait for a fresh SPISTE fall.

Structure
REQ-029 WORD_W default, SYNC_STAGES default and counter width SHALL be constants in shared package spi_pkg.
REQ-030 One sub-module, sync_edge (synchronizer + rise/fall detector, parameterized reset value), SHALL be instantiated for SCK, SPISIMO and SPISTE.

Verification
REQ-031 Single frame, master sends 16'h5A3C at 10 MHz, txd_data=16'hA55A -> rxd_data=16'h5A3C, one rxd_flag pulse, master receives 16'hA55A.
REQ-032 Two words in one SPISTE frame, 16'h4001 then 16'hC0FF; txd_data changed to 16'h1234 one cycle after first rxd_flag -> two rxd_flag pulses, second master word reads 16'h1234.
REQ-033 SPISTE raised after 7 bits -> frame_err one pulse, no rxd_flag, rxd_data retains previous 16'h5A3C, SPISOMI=0.
REQ-034 SCK toggled 16 times with SPISTE high -> no rxd_flag, rxd_data unchanged, SPISOMI=0.
REQ-035 RSTn pulsed low after bit 9 of 16'hFFFF -> all outputs 0, no pulses; following full frame 16'h8001 received correctly.
REQ-036 SCK at 12.5 MHz with 16'hFFFF/16'h0000 alternating words -> every word received and transmitted bit-exact.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the SPI slave core
package spi_pkg;

  localparam int WORD_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W           = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detection
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_100,
  input  logic RSTn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_100 or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~hist_q;
  assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI mode-0 slave, oversampled on clk_100
import spi_pkg::*;

module spi_slave_core #(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_100,
  input  logic              RSTn,
  input  logic              SCK,
  input  logic              SPISIMO,
  output logic              SPISOMI,
  input  logic              SPISTE,
  input  logic [WORD_W-1:0] txd_data,
  output logic [WORD_W-1:0] rxd_data,
  output logic              rxd_flag,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ARM_MAX  = CNT_W'(SYNC_STAGES + 1);

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic simo_lvl, simo_rise_unused, simo_fall_unused;
  logic ste_lvl, ste_rise, ste_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_100(clk_100), .RSTn(RSTn), .din(SCK),
    .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_simo (
    .clk_100(clk_100), .RSTn(RSTn), .din(SPISIMO),
    .dout(simo_lvl), .rise(simo_rise_unused), .fall(simo_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ste (
    .clk_100(clk_100), .RSTn(RSTn), .din(SPISTE),
    .dout(ste_lvl), .rise(ste_rise), .fall(ste_fall)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  arm_q, arm_d;
  logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_W-1:0] rxd_data_q, rxd_data_d;
  logic              somi_q, somi_d;
  logic              rxd_flag_q, rxd_flag_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    arm_d       = arm_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rxd_data_d  = rxd_data_q;
    somi_d      = somi_q;
    rxd_flag_d  = 1'b0;
    frame_err_d = 1'b0;

    // The STE synchronizer resets to "deselected"; only arm once that level has
    // truly propagated, so a select held low across reset cannot start a frame.
    if (arm_q != ARM_MAX) begin
      arm_d = ste_lvl ? arm_q + 1'b1 : '0;
    end

    case (state_q)
      ST_IDLE: begin
        somi_d = 1'b0;
        if (ste_fall && (arm_q == ARM_MAX)) begin
          state_d = ST_ACTIVE;
          tx_sr_d = txd_data;
          cnt_d   = '0;
          somi_d  = txd_data[WORD_W-1];
        end
      end
      ST_ACTIVE: begin
        if (ste_rise) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          rx_sr_d     = '0;
          somi_d      = 1'b0;
          frame_err_d = (cnt_q != '0) && (cnt_q < CNT_FULL);
        end else if (sck_rise && (cnt_q < CNT_FULL)) begin
          rx_sr_d = {rx_sr_q[WORD_W-2:0], simo_lvl};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            rxd_data_d = {rx_sr_q[WORD_W-2:0], simo_lvl};
            rxd_flag_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (cnt_q == CNT_FULL) begin
            tx_sr_d = txd_data;
            cnt_d   = '0;
            somi_d  = txd_data[WORD_W-1];
          end else if (cnt_q != '0) begin
            tx_sr_d = tx_sr_q << 1;
            somi_d  = tx_sr_q[WORD_W-2];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      arm_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rxd_data_q  <= '0;
      somi_q      <= 1'b0;
      rxd_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arm_q       <= arm_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rxd_data_q  <= rxd_data_d;
      somi_q      <= somi_d;
      rxd_flag_q  <= rxd_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign SPISOMI   = somi_q;
  assign rxd_data  = rxd_data_q;
  assign rxd_flag  = rxd_flag_q;
  assign frame_err = frame_err_q;

endmodule
